conv_layer_ctrl: RTL and testbench
==================================

CONV_LAYER_CTRL -- requirements
Module: conv_layer_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- G_KERNEL_SIZE, 5, kernel edge.
- G_IMAGE_HEIGHT, 28, ifmap rows.
- G_IMAGE_WIDTH, 28, ifmap cols.
- G_WEIGHT_BUF_ADDR_WIDTH, 5, weight BRAM addr bits.
- G_IFMAP_BUF_ADDR_WIDTH, 10, ifmap BRAM addr bits.
- G_TOP_BITS, 2, integer bits.
- G_BOT_BITS, 14, fraction bits.
- G_MAX_KERNELS, 8, max kernels per layer.
REQ-002 Ports SHALL be (name direction width meaning); D = G_TOP_BITS+G_BOT_BITS, KW = $clog2(G_MAX_KERNELS)+1:
- clk_i, in, 1, single clock.
- rst_ni, in, 1, reset; asynchronous, active-low.
- cfg_valid_i / cfg_ready_o, in/out, 1, layer-start handshake.
- cfg_num_kernels_i, in, KW, kernels this layer.
- s_valid_i / s_ready_o, in/out, 1, load-stream handshake.
- s_data_i, in, D, load-stream word.
- ifmap_wr_addr_o, out, G_IFMAP_BUF_ADDR_WIDTH, ifmap BRAM write address.
- ifmap_wr_en_o, out, 1, ifmap BRAM write enable.
- weight_wr_addr_o, out, G_WEIGHT_BUF_ADDR_WIDTH, weight BRAM write address.
- weight_wr_en_o, out, 1, weight BRAM write enable.
- wr_data_o, out, D, shared BRAM write data.
- buf_start_o, out, 1, buffer-array start pulse.
- buf_done_i, in, 1, buffer-array done.
- busy_o, out, 1, layer in progress.
- kernel_idx_o, out, KW, current kernel.
- kernel_done_o, out, 1, one-cycle pulse per kernel.
- layer_done_o, out, 1, one-cycle pulse per layer.

Function
REQ-003 States SHALL be IDLE, LOAD_I, LOAD_W, START, RUN, NEXT.
REQ-004 IDLE: cfg_ready_o=1. A cfg handshake with cfg_num_kernels_i in 1..G_MAX_KERNELS SHALL latch the count, clear kernel_idx_o and enter LOAD_I. A value of 0 or above G_MAX_KERNELS SHALL be accepted and ignored, staying in IDLE.
REQ-005 s_ready_o SHALL be 1 only in LOAD_I and LOAD_W; stream order is ifmap row-major (H*W words), then K*K weights row-major per kernel.
REQ-006 Each accepted beat SHALL drive the matching wr_en_o, address and wr_data_o exactly one cycle later (registered); the address counter starts at 0 and increments by 1 per beat.
REQ-007 LOAD_I SHALL leave after beat H*W-1 is accepted, entering LOAD_W with the weight address cleared; LOAD_W SHALL leave after beat K*K-1 is accepted, entering START.
REQ-008 START SHALL last exactly one cycle, so buf_start_o is asserted one cycle, and SHALL enter RUN; the last weight write is visible to the BRAM before buf_start_o.
REQ-009 RUN SHALL wait for buf_done_i=1, then enter NEXT; buf_done_i outside RUN SHALL be ignored.
REQ-010 NEXT SHALL pulse kernel_done_o for one cycle. If kernel_idx_o equals count-1, it SHALL pulse layer_done_o in the same cycle and enter IDLE; otherwise it SHALL increment kernel_idx_o and enter LOAD_W (the ifmap is reused, not reloaded).
REQ-011 busy_o SHALL be 1 in every state except IDLE.
REQ-012 Address counters SHALL never wrap. A stall (s_valid_i=0) SHALL hold all counters and emit no write.
REQ-013 Write enables SHALL never be asserted in START, RUN, NEXT or IDLE, except for the single registered write trailing the final accepted beat.

Reset
REQ-014 On rst_ni=0 the block SHALL asynchronously enter IDLE. All outputs SHALL read 0 except cfg_ready_o, which SHALL read 1. Counters and the latched count SHALL clear.
REQ-015 Reset mid-operation SHALL abandon the layer without emitting pulses; after release, the first cfg handshake SHALL start cleanly.

Structure
REQ-016 The state enum and the derived constants (IFMAP_WORDS_C=H*W, WEIGHT_WORDS_C=K*K) SHALL reside in a shared package conv_pkg.
REQ-017 One sub-module, load_addr_counter (enable, clear, terminal-count flag), SHALL be instantiated once for each BRAM.

Verification
REQ-018 Benches SHALL cover:
- cfg count=1, 784 ifmap beats and 25 weight beats streamed back-to-back -> ifmap addresses 0..783 and weight addresses 0..24, one write each; buf_start_o one cycle after the last weight write.
- count=3 with buf_done_i returned 10 cycles after each start -> 3 kernel_done_o pulses, kernel_idx_o 0,1,2, ifmap loaded once, 75 weight writes, layer_done_o coincident with the third kernel_done_o.
- s_valid_i toggled randomly at 50% -> identical write sequence, no write in stall cycles.
- cfg count=0 and count=9 -> no state change, busy_o stays 0.
- rst_ni low during LOAD_W at weight beat 12 -> all outputs at reset values immediately; a new cfg then runs to completion.
- buf_done_i=1 during LOAD_I -> ignored; RUN still waits for a later buf_done_i.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and size helpers for the convolution layer controller.
// The enum is the controller's phase; the helpers turn geometry into word counts.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_I,
        ST_LOAD_W,
        ST_START,
        ST_RUN,
        ST_NEXT
    } conv_state_e;

    localparam int KERNEL_SIZE_C  = 5;
    localparam int IMAGE_HEIGHT_C = 28;
    localparam int IMAGE_WIDTH_C  = 28;
    localparam int IFMAP_WORDS_C  = IMAGE_HEIGHT_C * IMAGE_WIDTH_C;
    localparam int WEIGHT_WORDS_C = KERNEL_SIZE_C * KERNEL_SIZE_C;

    function automatic int ifmap_words(input int height, input int width);
        return height * width;
    endfunction

    function automatic int weight_words(input int kernel_size);
        return kernel_size * kernel_size;
    endfunction

endpackage

// File: rtl/load_addr_counter.sv
// BRAM load address counter: clears to 0, advances one per enabled beat and
// parks on the terminal value instead of wrapping.
module load_addr_counter #(
    parameter int G_WIDTH    = 10,
    parameter int G_TERMINAL = 783
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               en_i,
    output logic [G_WIDTH-1:0] count_o,
    output logic               last_o
);

    localparam logic [G_WIDTH-1:0] TERMINAL_C = G_TERMINAL[G_WIDTH-1:0];

    logic [G_WIDTH-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (clear_i) begin
            count_reg <= '0;
        end else if (en_i && !last_o) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count_o = count_reg;
    assign last_o  = (count_reg == TERMINAL_C);

endmodule

// File: rtl/conv_layer_ctrl.sv
// Layer sequencer: streams the ifmap once and each kernel's weights into BRAM,
// then starts the buffer array per kernel and reports kernel/layer completion.
module conv_layer_ctrl
    import conv_pkg::*;
#(
    parameter int G_KERNEL_SIZE           = 5,
    parameter int G_IMAGE_HEIGHT          = 28,
    parameter int G_IMAGE_WIDTH           = 28,
    parameter int G_WEIGHT_BUF_ADDR_WIDTH = 5,
    parameter int G_IFMAP_BUF_ADDR_WIDTH  = 10,
    parameter int G_TOP_BITS              = 2,
    parameter int G_BOT_BITS              = 14,
    parameter int G_MAX_KERNELS           = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                cfg_valid_i,
    output logic                                cfg_ready_o,
    input  logic [$clog2(G_MAX_KERNELS):0]      cfg_num_kernels_i,
    input  logic                                s_valid_i,
    output logic                                s_ready_o,
    input  logic [G_TOP_BITS+G_BOT_BITS-1:0]    s_data_i,
    output logic [G_IFMAP_BUF_ADDR_WIDTH-1:0]   ifmap_wr_addr_o,
    output logic                                ifmap_wr_en_o,
    output logic [G_WEIGHT_BUF_ADDR_WIDTH-1:0]  weight_wr_addr_o,
    output logic                                weight_wr_en_o,
    output logic [G_TOP_BITS+G_BOT_BITS-1:0]    wr_data_o,
    output logic                                buf_start_o,
    input  logic                                buf_done_i,
    output logic                                busy_o,
    output logic [$clog2(G_MAX_KERNELS):0]      kernel_idx_o,
    output logic                                kernel_done_o,
    output logic                                layer_done_o
);

    localparam int KW           = $clog2(G_MAX_KERNELS) + 1;
    localparam int D            = G_TOP_BITS + G_BOT_BITS;
    localparam int IFMAP_WORDS  = ifmap_words(G_IMAGE_HEIGHT, G_IMAGE_WIDTH);
    localparam int WEIGHT_WORDS = weight_words(G_KERNEL_SIZE);
    localparam logic [KW-1:0] MAX_K_C = KW'(G_MAX_KERNELS);

    conv_state_e state_reg, state_next;

    logic [KW-1:0] num_kernels_reg;
    logic [KW-1:0] kernel_idx_reg;
    logic [KW-1:0] kernel_idx_inc;
    logic          kernel_last;
    logic          cfg_ok;
    logic          beat_i;
    logic          beat_w;

    logic [G_IFMAP_BUF_ADDR_WIDTH-1:0]  ifmap_cnt;
    logic [G_WEIGHT_BUF_ADDR_WIDTH-1:0] weight_cnt;
    logic                               ifmap_last;
    logic                               weight_last;

    logic [G_IFMAP_BUF_ADDR_WIDTH-1:0]  ifmap_wr_addr_reg;
    logic [G_WEIGHT_BUF_ADDR_WIDTH-1:0] weight_wr_addr_reg;
    logic                               ifmap_wr_en_reg;
    logic                               weight_wr_en_reg;
    logic [D-1:0]                       wr_data_reg;
    logic                               buf_start_reg;

    assign cfg_ok = cfg_valid_i && (cfg_num_kernels_i != '0) && (cfg_num_kernels_i <= MAX_K_C);
    assign beat_i = (state_reg == ST_LOAD_I) && s_valid_i;
    assign beat_w = (state_reg == ST_LOAD_W) && s_valid_i;

    assign kernel_idx_inc = kernel_idx_reg + 1'b1;
    assign kernel_last    = (kernel_idx_inc == num_kernels_reg);

    // The ifmap counter is held at 0 while idle; the weight counter is held at 0
    // outside LOAD_W, so every kernel's weights land at addresses 0..K*K-1.
    load_addr_counter #(
        .G_WIDTH    (G_IFMAP_BUF_ADDR_WIDTH),
        .G_TERMINAL (IFMAP_WORDS - 1)
    ) u_ifmap_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (state_reg == ST_IDLE),
        .en_i    (beat_i),
        .count_o (ifmap_cnt),
        .last_o  (ifmap_last)
    );

    load_addr_counter #(
        .G_WIDTH    (G_WEIGHT_BUF_ADDR_WIDTH),
        .G_TERMINAL (WEIGHT_WORDS - 1)
    ) u_weight_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (state_reg != ST_LOAD_W),
        .en_i    (beat_w),
        .count_o (weight_cnt),
        .last_o  (weight_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:   if (cfg_ok) state_next = ST_LOAD_I;
            ST_LOAD_I: if (beat_i && ifmap_last) state_next = ST_LOAD_W;
            ST_LOAD_W: if (beat_w && weight_last) state_next = ST_START;
            ST_START:  state_next = ST_RUN;
            ST_RUN:    if (buf_done_i) state_next = ST_NEXT;
            ST_NEXT:   state_next = kernel_last ? ST_IDLE : ST_LOAD_W;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_kernels_reg <= '0;
            kernel_idx_reg  <= '0;
        end else if ((state_reg == ST_IDLE) && cfg_ok) begin
            num_kernels_reg <= cfg_num_kernels_i;
            kernel_idx_reg  <= '0;
        end else if ((state_reg == ST_NEXT) && !kernel_last) begin
            kernel_idx_reg  <= kernel_idx_inc;
        end
    end

    // Writes trail their beat by one cycle; buf_start is delayed one more so the
    // final weight write has committed before the buffer array starts reading.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ifmap_wr_en_reg    <= 1'b0;
            weight_wr_en_reg   <= 1'b0;
            ifmap_wr_addr_reg  <= '0;
            weight_wr_addr_reg <= '0;
            wr_data_reg        <= '0;
            buf_start_reg      <= 1'b0;
        end else begin
            ifmap_wr_en_reg  <= beat_i;
            weight_wr_en_reg <= beat_w;
            buf_start_reg    <= (state_reg == ST_START);
            if (beat_i) begin
                ifmap_wr_addr_reg <= ifmap_cnt;
            end
            if (beat_w) begin
                weight_wr_addr_reg <= weight_cnt;
            end
            if (beat_i || beat_w) begin
                wr_data_reg <= s_data_i;
            end
        end
    end

    assign cfg_ready_o      = (state_reg == ST_IDLE);
    assign s_ready_o        = (state_reg == ST_LOAD_I) || (state_reg == ST_LOAD_W);
    assign busy_o           = (state_reg != ST_IDLE);
    assign kernel_done_o    = (state_reg == ST_NEXT);
    assign layer_done_o     = (state_reg == ST_NEXT) && kernel_last;
    assign kernel_idx_o     = kernel_idx_reg;
    assign ifmap_wr_en_o    = ifmap_wr_en_reg;
    assign weight_wr_en_o   = weight_wr_en_reg;
    assign ifmap_wr_addr_o  = ifmap_wr_addr_reg;
    assign weight_wr_addr_o = weight_wr_addr_reg;
    assign wr_data_o        = wr_data_reg;
    assign buf_start_o      = buf_start_reg;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Bench for conv_layer_ctrl: a phase-level model predicts every output each cycle,
// and per-scenario event totals are pinned to hand-computed literals.
module tb_conv_layer_ctrl;

    localparam int NI = 784;
    localparam int NW = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [3:0]  cfg_num = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic [9:0]  ifmap_wr_addr;
    logic        ifmap_wr_en;
    logic [4:0]  weight_wr_addr;
    logic        weight_wr_en;
    logic [15:0] wr_data;
    logic        buf_start;
    logic        buf_done = 1'b0;
    logic        busy;
    logic [3:0]  kernel_idx;
    logic        kernel_done;
    logic        layer_done;

    conv_layer_ctrl #(
        .G_KERNEL_SIZE(5), .G_IMAGE_HEIGHT(28), .G_IMAGE_WIDTH(28),
        .G_WEIGHT_BUF_ADDR_WIDTH(5), .G_IFMAP_BUF_ADDR_WIDTH(10),
        .G_TOP_BITS(2), .G_BOT_BITS(14), .G_MAX_KERNELS(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_num_kernels_i(cfg_num),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .ifmap_wr_addr_o(ifmap_wr_addr), .ifmap_wr_en_o(ifmap_wr_en),
        .weight_wr_addr_o(weight_wr_addr), .weight_wr_en_o(weight_wr_en),
        .wr_data_o(wr_data), .buf_start_o(buf_start), .buf_done_i(buf_done),
        .busy_o(busy), .kernel_idx_o(kernel_idx),
        .kernel_done_o(kernel_done), .layer_done_o(layer_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    longint cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model phases: 0 idle, 1 ifmap stream, 2 weight stream, 3 start, 4 wait done, 5 kernel end.
    int          m_mode = 0, m_count = 0, m_kidx = 0, m_ib = 0, m_wb = 0;
    bit          m_pi = 0, m_pw = 0, m_start = 0;
    int          m_pi_addr = 0, m_pw_addr = 0;
    logic [15:0] m_pdata = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; m_count = 0; m_kidx = 0; m_ib = 0; m_wb = 0;
            m_pi = 0; m_pw = 0; m_start = 0;
        end else begin
            cyc++;
            m_pi = (m_mode == 1) && s_valid;
            m_pw = (m_mode == 2) && s_valid;
            m_start = (m_mode == 3);
            if (m_pi) begin m_pi_addr = m_ib; m_pdata = s_data; end
            if (m_pw) begin m_pw_addr = m_wb; m_pdata = s_data; end
            case (m_mode)
                0: if (cfg_valid && cfg_num >= 1 && cfg_num <= 8) begin
                       m_count = int'(cfg_num); m_kidx = 0; m_ib = 0; m_mode = 1;
                   end
                1: if (s_valid) begin
                       m_ib++;
                       if (m_ib == NI) begin m_mode = 2; m_wb = 0; end
                   end
                2: if (s_valid) begin
                       m_wb++;
                       if (m_wb == NW) m_mode = 3;
                   end
                3: m_mode = 4;
                4: if (buf_done) m_mode = 5;
                5: if (m_kidx == m_count - 1) m_mode = 0;
                   else begin m_kidx++; m_wb = 0; m_mode = 2; end
                default: m_mode = 0;
            endcase
        end
    end

    int     ev_iw = 0, ev_ww = 0, ev_kd = 0, ev_ld = 0;
    longint last_ww_cyc = 0;
    int     kidx_log[$];

    initial forever begin
        @(negedge clk);
        chk("cfg_ready", 32'(cfg_ready), 32'(m_mode == 0));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("s_ready", 32'(s_ready), 32'(m_mode == 1 || m_mode == 2));
        chk("ifmap_wr_en", 32'(ifmap_wr_en), 32'(m_pi));
        chk("weight_wr_en", 32'(weight_wr_en), 32'(m_pw));
        chk("buf_start", 32'(buf_start), 32'(m_start));
        chk("kernel_idx", 32'(kernel_idx), 32'(m_kidx));
        chk("kernel_done", 32'(kernel_done), 32'(m_mode == 5));
        chk("layer_done", 32'(layer_done), 32'(m_mode == 5 && m_kidx == m_count - 1));
        if (m_pi) begin
            chk("ifmap_addr", 32'(ifmap_wr_addr), 32'(m_pi_addr));
            chk("ifmap_data", 32'(wr_data), 32'(m_pdata));
        end
        if (m_pw) begin
            chk("weight_addr", 32'(weight_wr_addr), 32'(m_pw_addr));
            chk("weight_data", 32'(wr_data), 32'(m_pdata));
        end
        if (ifmap_wr_en) ev_iw++;
        if (weight_wr_en) begin ev_ww++; last_ww_cyc = cyc; end
        if (buf_start) chk("start_after_last_wwr", 32'(cyc - last_ww_cyc), 32'd1);
        if (kernel_done) begin ev_kd++; kidx_log.push_back(int'(kernel_idx)); end
        if (layer_done) ev_ld++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        ev_iw = 0; ev_ww = 0; ev_kd = 0; ev_ld = 0;
        kidx_log.delete();
    endtask

    task automatic do_cfg(input logic [3:0] n);
        cfg_valid = 1'b1;
        cfg_num   = n;
        tick();
        cfg_valid = 1'b0;
        cfg_num   = '0;
    endtask

    task automatic stream(input int n, input logic [15:0] base, input bit rnd);
        int  got = 0;
        int  budget = 0;
        bit  acc;
        while (got < n && budget < 4000) begin
            s_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_data  = base + 16'(got);
            acc     = s_valid && s_ready;
            tick();
            if (acc) got++;
            budget++;
        end
        s_valid = 1'b0;
        if (got < n) chk("stream_timeout", 32'(got), 32'(n));
    endtask

    task automatic finish_kernel(input int delay);
        int b = 0;
        while (!buf_start && b < 100) begin tick(); b++; end
        if (b >= 100) chk("start_timeout", 32'(b), 32'd0);
        repeat (delay) tick();
        buf_done = 1'b1;
        tick();
        buf_done = 1'b0;
    endtask

    task automatic run_layer(input int n, input bit rnd, input bit early_done);
        do_cfg(4'(n));
        if (early_done) begin
            buf_done = 1'b1;
            tick(); tick();
            buf_done = 1'b0;
        end
        stream(NI, 16'h1000, rnd);
        for (int k = 0; k < n; k++) begin
            stream(NW, 16'h8000 + 16'(k * 32), rnd);
            finish_kernel(10);
        end
        tick(); tick();
    endtask

    task automatic pin_totals(input string tag, input int iw, input int ww, input int kd, input int ld);
        chk({tag, "_ifmap_writes"}, 32'(ev_iw), 32'(iw));
        chk({tag, "_weight_writes"}, 32'(ev_ww), 32'(ww));
        chk({tag, "_kernel_done"}, 32'(ev_kd), 32'(kd));
        chk({tag, "_layer_done"}, 32'(ev_ld), 32'(ld));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'({ifmap_wr_en, weight_wr_en}), 32'd0);
        chk({tag, "_addrs"}, 32'({ifmap_wr_addr, weight_wr_addr}), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_pulses"}, 32'({buf_start, kernel_done, layer_done}), 32'd0);
        chk({tag, "_kernel_idx"}, 32'(kernel_idx), 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        $display("T1: one kernel, back-to-back stream");
        clear_events();
        run_layer(1, 1'b0, 1'b0);
        pin_totals("t1", 784, 25, 1, 1);

        $display("T2: three kernels, buf_done during ifmap load ignored");
        clear_events();
        run_layer(3, 1'b0, 1'b1);
        pin_totals("t2", 784, 75, 3, 1);
        chk("t2_kidx_log_len", 32'(kidx_log.size()), 32'd3);
        for (int i = 0; i < kidx_log.size() && i < 3; i++)
            chk("t2_kidx_at_done", 32'(kidx_log[i]), 32'(i));

        $display("T3: two kernels, 50%% random stalls");
        clear_events();
        run_layer(2, 1'b1, 1'b0);
        pin_totals("t3", 784, 50, 2, 1);

        $display("T4: illegal counts 0 and 9 ignored");
        clear_events();
        do_cfg(4'd0);
        repeat (3) tick();
        chk("t4_busy_after_0", 32'(busy), 32'd0);
        do_cfg(4'd9);
        repeat (3) tick();
        chk("t4_busy_after_9", 32'(busy), 32'd0);
        chk("t4_cfg_ready", 32'(cfg_ready), 32'd1);
        pin_totals("t4", 0, 0, 0, 0);

        $display("T5: reset at weight beat 12, then a clean layer");
        clear_events();
        do_cfg(4'd2);
        stream(NI, 16'h2000, 1'b0);
        stream(12, 16'h9000, 1'b0);
        s_valid = 1'b1;
        s_data  = 16'h900c;
        rst_n   = 1'b0;
        #1 chk_reset_outputs("t5_mid");
        tick(); tick();
        s_valid = 1'b0;
        rst_n   = 1'b1;
        tick();
        chk("t5_no_pulses", 32'(ev_kd + ev_ld), 32'd0);
        clear_events();
        run_layer(1, 1'b0, 1'b0);
        pin_totals("t5_after", 784, 25, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
